// File: rtl/top.sv
// top: accumulator-style datapath with a 16-bit common bus, register file and 4K x 16 memory

// sram: 4096 x 16 word memory, combinational read, write on rising clk
module sram (
  input  logic        clk,
  input  logic        we,
  input  logic [11:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata
);
  logic [15:0] mem [0:4095];
  assign rdata = mem[addr];
  // contents are never reset so preloaded data survives rst
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
endmodule

// cpu: bus source mux and the IR/DR/AC/AR/PC registers loaded from the bus
module cpu (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  sel,
  input  logic [5:0]  load,
  input  logic [15:0] mem_rdata,
  output logic [15:0] bus,
  output logic [11:0] addr,
  output logic        mem_we
);
  logic [15:0] IR, DR, AC;
  logic [11:0] AR, PC;
  assign addr   = AR;
  assign mem_we = load[0] & ~rst;
  // common bus source select; unused codes drive zero
  always_comb begin
    bus = 16'h0000;
    case (sel)
      3'b001:  bus = IR;
      3'b010:  bus = DR;
      3'b011:  bus = AC;
      3'b100:  bus = {4'b0, AR};
      3'b101:  bus = mem_rdata;
      3'b110:  bus = {4'b0, PC};
      default: bus = 16'h0000;
    endcase
  end
  // every enabled destination captures the same pre-edge bus; 12-bit targets truncate
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      IR <= '0;
      DR <= '0;
      AC <= '0;
      AR <= '0;
      PC <= '0;
    end else begin
      if (load[5]) AR <= bus[11:0];
      if (load[4]) DR <= bus;
      if (load[3]) PC <= bus[11:0];
      if (load[2]) AC <= bus;
      if (load[1]) IR <= bus;
    end
endmodule

module top (
  input logic       clk,
  input logic       rst,
  input logic [2:0] sel,
  input logic [5:0] load
);
  logic [15:0] bus, rdata;
  logic [11:0] addr;
  logic        we;
  cpu cpu_0 (
    .clk(clk), .rst(rst), .sel(sel), .load(load),
    .mem_rdata(rdata), .bus(bus), .addr(addr), .mem_we(we)
  );
  sram sram_0 (
    .clk(clk), .we(we), .addr(addr), .wdata(bus), .rdata(rdata)
  );
endmodule

// File: tb/tb_top.sv
// tb_top: table-driven scoreboard bench for the bus datapath
module tb_top;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] sel = 3'b000;
  logic [5:0] load = 6'b000000;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  sel;
    logic [5:0]  load;
    logic [15:0] ir, dr, ac;
    logic [11:0] ar, pc;
    logic [11:0] maddr;
    logic [15:0] mdata;
  } vec_t;

  vec_t vec [17];
  vec_t sb [$];

  top dut (.clk(clk), .rst(rst), .sel(sel), .load(load));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input vec_t e);
    chk({tag, ".IR"}, dut.cpu_0.IR, e.ir);
    chk({tag, ".DR"}, dut.cpu_0.DR, e.dr);
    chk({tag, ".AC"}, dut.cpu_0.AC, e.ac);
    chk({tag, ".AR"}, {4'b0, dut.cpu_0.AR}, {4'b0, e.ar});
    chk({tag, ".PC"}, {4'b0, dut.cpu_0.PC}, {4'b0, e.pc});
  endtask

  initial begin
    vec_t e, z;
    vec[0]  = '{3'b101, 6'b000010, 16'h0003, 16'h0000, 16'h0000, 12'h000, 12'h000, 12'h000, 16'h0003};
    vec[1]  = '{3'b001, 6'b100000, 16'h0003, 16'h0000, 16'h0000, 12'h003, 12'h000, 12'h003, 16'h00AB};
    vec[2]  = '{3'b101, 6'b010000, 16'h0003, 16'h00AB, 16'h0000, 12'h003, 12'h000, 12'h003, 16'h00AB};
    vec[3]  = '{3'b010, 6'b001100, 16'h0003, 16'h00AB, 16'h00AB, 12'h003, 12'h0AB, 12'h003, 16'h00AB};
    vec[4]  = '{3'b001, 6'b000001, 16'h0003, 16'h00AB, 16'h00AB, 12'h003, 12'h0AB, 12'h003, 16'h0003};
    vec[5]  = '{3'b101, 6'b000100, 16'h0003, 16'h00AB, 16'h0003, 12'h003, 12'h0AB, 12'h003, 16'h0003};
    vec[6]  = '{3'b101, 6'b000000, 16'h0003, 16'h00AB, 16'h0003, 12'h003, 12'h0AB, 12'h003, 16'h0003};
    vec[7]  = '{3'b110, 6'b100000, 16'h0003, 16'h00AB, 16'h0003, 12'h0AB, 12'h0AB, 12'h0AB, 16'hF125};
    vec[8]  = '{3'b101, 6'b101000, 16'h0003, 16'h00AB, 16'h0003, 12'h125, 12'h125, 12'h0AB, 16'hF125};
    vec[9]  = '{3'b101, 6'b000010, 16'hBEEF, 16'h00AB, 16'h0003, 12'h125, 12'h125, 12'h125, 16'hBEEF};
    vec[10] = '{3'b011, 6'b000001, 16'hBEEF, 16'h00AB, 16'h0003, 12'h125, 12'h125, 12'h125, 16'h0003};
    vec[11] = '{3'b000, 6'b100001, 16'hBEEF, 16'h00AB, 16'h0003, 12'h000, 12'h125, 12'h125, 16'h0000};
    vec[12] = '{3'b101, 6'b000001, 16'hBEEF, 16'h00AB, 16'h0003, 12'h000, 12'h125, 12'h000, 16'h0003};
    vec[13] = '{3'b001, 6'b000010, 16'hBEEF, 16'h00AB, 16'h0003, 12'h000, 12'h125, 12'h000, 16'h0003};
    vec[14] = '{3'b111, 6'b010000, 16'hBEEF, 16'h0000, 16'h0003, 12'h000, 12'h125, 12'h003, 16'h0003};
    vec[15] = '{3'b110, 6'b000100, 16'hBEEF, 16'h0000, 16'h0125, 12'h000, 12'h125, 12'h125, 16'h0000};
    vec[16] = '{3'b100, 6'b001000, 16'hBEEF, 16'h0000, 16'h0125, 12'h000, 12'h000, 12'h000, 16'h0003};
    z = '{3'b000, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 12'h000, 12'h000, 12'h000, 16'h0000};
    dut.sram_0.mem[12'h000] <= 16'h0003;
    dut.sram_0.mem[12'h003] <= 16'h00AB;
    dut.sram_0.mem[12'h0AB] <= 16'hF125;
    dut.sram_0.mem[12'h125] <= 16'hBEEF;
    repeat (2) @(negedge clk);
    chk_regs("reset", z);
    chk("reset.mem0", dut.sram_0.mem[12'h000], 16'h0003);
    chk("reset.mem3", dut.sram_0.mem[12'h003], 16'h00AB);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      sel = vec[i].sel;
      load = vec[i].load;
      sb.push_back(vec[i]);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty step=%0d", i);
      end else begin
        e = sb.pop_front();
        chk_regs($sformatf("step%0d", i), e);
        chk($sformatf("step%0d.mem[%h]", i, e.maddr), dut.sram_0.mem[e.maddr], e.mdata);
      end
    end
    @(negedge clk);
    sel = 3'b101;
    load = 6'b111110;
    #2;
    rst = 1'b1;
    #1;
    chk_regs("async_rst", z);
    @(negedge clk);
    sel = 3'b000;
    load = 6'b111111;
    @(posedge clk);
    #1;
    chk_regs("held_rst", z);
    chk("held_rst.mem0", dut.sram_0.mem[12'h000], 16'h0003);
    chk("held_rst.mem3", dut.sram_0.mem[12'h003], 16'h0003);
    @(negedge clk);
    rst = 1'b0;
    sel = 3'b101;
    load = 6'b000010;
    @(posedge clk);
    #1;
    chk("resume.IR", dut.cpu_0.IR, 16'h0003);
    chk("resume.AR", {4'b0, dut.cpu_0.AR}, 16'h0000);
    @(negedge clk);
    load = 6'b000000;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
